// File: rtl/fas_fft_frame_serializer.sv
// Ping-pong frame buffer between the FAS FFT parallel result bus and a
// point-serial valid/ready host stream; overlapping frames beyond two are dropped.
module fas_fft_frame_serializer #(
    parameter int DW  = 32,
    parameter int NPT = 16,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fft_valid,
    input  logic [DW-1:0] fft_d0,
    input  logic [DW-1:0] fft_d1,
    input  logic [DW-1:0] fft_d2,
    input  logic [DW-1:0] fft_d3,
    input  logic [DW-1:0] fft_d4,
    input  logic [DW-1:0] fft_d5,
    input  logic [DW-1:0] fft_d6,
    input  logic [DW-1:0] fft_d7,
    input  logic [DW-1:0] fft_d8,
    input  logic [DW-1:0] fft_d9,
    input  logic [DW-1:0] fft_d10,
    input  logic [DW-1:0] fft_d11,
    input  logic [DW-1:0] fft_d12,
    input  logic [DW-1:0] fft_d13,
    input  logic [DW-1:0] fft_d14,
    input  logic [DW-1:0] fft_d15,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_idx,
    output logic          out_last,
    output logic [CW-1:0] frame_cnt,
    output logic [CW-1:0] drop_cnt,
    output logic          overflow,
    output logic          busy
);
    localparam logic [3:0] LAST_IDX = 4'(NPT - 1);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] bank [2][NPT];
    logic [DW-1:0] din [NPT];
    logic [1:0]    full, full_nxt, free;
    logic          wr_sel, rd_sel, rd_sel_nxt;
    logic          cap, drop, frame_inc;
    logic [3:0]    idx_inc, idx_nxt;
    logic          vld_nxt, last_nxt;
    logic [DW-1:0] data_nxt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign din[0]  = fft_d0;
    assign din[1]  = fft_d1;
    assign din[2]  = fft_d2;
    assign din[3]  = fft_d3;
    assign din[4]  = fft_d4;
    assign din[5]  = fft_d5;
    assign din[6]  = fft_d6;
    assign din[7]  = fft_d7;
    assign din[8]  = fft_d8;
    assign din[9]  = fft_d9;
    assign din[10] = fft_d10;
    assign din[11] = fft_d11;
    assign din[12] = fft_d12;
    assign din[13] = fft_d13;
    assign din[14] = fft_d14;
    assign din[15] = fft_d15;

    assign idx_inc = out_idx + 4'd1;
    assign busy    = |full;

    always_comb begin
        state_nxt  = state;
        rd_sel_nxt = rd_sel;
        idx_nxt    = out_idx;
        vld_nxt    = out_valid;
        data_nxt   = out_data;
        last_nxt   = out_last;
        frame_inc  = 1'b0;
        free       = 2'b00;
        case (state)
            ST_IDLE: begin
                if (full[rd_sel]) begin
                    state_nxt = ST_SEND;
                    idx_nxt   = 4'd0;
                    vld_nxt   = 1'b1;
                    data_nxt  = bank[rd_sel][0];
                    last_nxt  = 1'b0;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (out_idx == LAST_IDX) begin
                        free[rd_sel] = 1'b1;
                        rd_sel_nxt   = ~rd_sel;
                        frame_inc    = 1'b1;
                        idx_nxt      = 4'd0;
                        last_nxt     = 1'b0;
                        // Back-to-back frames continue without a bubble cycle
                        if (full[~rd_sel]) begin
                            data_nxt = bank[~rd_sel][0];
                        end else begin
                            state_nxt = ST_IDLE;
                            vld_nxt   = 1'b0;
                        end
                    end else begin
                        idx_nxt  = idx_inc;
                        data_nxt = bank[rd_sel][idx_inc];
                        last_nxt = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A bank released by the final handshake is reusable at the same edge
        cap      = fft_valid && (!full[wr_sel] || free[wr_sel]);
        drop     = fft_valid && !cap;
        full_nxt = full & ~free;
        if (cap) full_nxt[wr_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            for (int i = 0; i < NPT; i++) bank[wr_sel][i] <= din[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            full      <= 2'b00;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= 4'd0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            full      <= full_nxt;
            rd_sel    <= rd_sel_nxt;
            out_valid <= vld_nxt;
            out_data  <= data_nxt;
            out_idx   <= idx_nxt;
            out_last  <= last_nxt;
            if (cap) wr_sel <= ~wr_sel;
            if (frame_inc) frame_cnt <= frame_cnt + 1'b1;
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fas_fft_frame_serializer.sv
// Bench for fas_fft_frame_serializer: queue-based frame model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_fas_fft_frame_serializer;
    logic        clk;
    logic        rst;
    logic        fft_valid;
    logic [31:0] din [16];
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic [7:0]  frame_cnt;
    logic [7:0]  drop_cnt;
    logic        overflow;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    fas_fft_frame_serializer #(.DW(32), .NPT(16), .CW(8)) dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(din[0]),   .fft_d1(din[1]),   .fft_d2(din[2]),   .fft_d3(din[3]),
        .fft_d4(din[4]),   .fft_d5(din[5]),   .fft_d6(din[6]),   .fft_d7(din[7]),
        .fft_d8(din[8]),   .fft_d9(din[9]),   .fft_d10(din[10]), .fft_d11(din[11]),
        .fft_d12(din[12]), .fft_d13(din[13]), .fft_d14(din[14]), .fft_d15(din[15]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .frame_cnt(frame_cnt),
        .drop_cnt(drop_cnt), .overflow(overflow), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pt(input int f, input int n);
        return 32'(f) * 32'h01000100 + 32'h00010000 * 32'(n) + 32'(n);
    endfunction

    // Model: stored frames as a flat point queue (16 per frame, oldest first)
    logic [31:0] mq[$];
    bit  m_send = 0;
    int  m_pos = 0;
    int  m_frames = 0;
    int  m_drops = 0;
    int  m_nfr;
    bit  m_fin, m_acc;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_send   = 0;
            m_pos    = 0;
            m_frames = 0;
            m_drops  = 0;
        end else begin
            m_nfr = mq.size() / 16;
            m_fin = m_send && out_ready && (m_pos == 15);
            m_acc = fft_valid && (m_nfr < 2 || m_fin);
            if (fft_valid && !m_acc) m_drops++;
            if (m_send && out_ready) begin
                if (m_fin) begin
                    repeat (16) void'(mq.pop_front());
                    m_frames++;
                    m_pos  = 0;
                    m_send = (m_nfr == 2);
                end else begin
                    m_pos++;
                end
            end else if (!m_send && m_nfr >= 1) begin
                m_send = 1;
                m_pos  = 0;
            end
            if (m_acc) for (int i = 0; i < 16; i++) mq.push_back(din[i]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_send);
            if (m_send) begin
                check("out_data", out_data, mq[m_pos]);
                check("out_idx", out_idx, m_pos);
                check("out_last", out_last, m_pos == 15);
            end
            check("frame_cnt", frame_cnt, m_frames % 256);
            check("drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);
            check("overflow", overflow, m_drops > 0);
            check("busy", busy, mq.size() != 0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fft_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic put_frame(input int f);
        for (int i = 0; i < 16; i++) din[i] = pt(f, i);
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
    endtask

    task automatic wait_idx(input logic [3:0] tgt, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid && out_idx == tgt) begin
                ok = 1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (!out_valid && !busy) begin
                ok = 1;
                return;
            end
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int hs;
        rst = 1'b0;
        fft_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) din[i] = '0;

        // Reset state
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        chk_en = 1;

        // Single frame, sink always ready
        out_ready = 1'b1;
        put_frame(0);
        check("t1_valid_not_yet", out_valid, 0);
        tick();
        for (int k = 0; k < 16; k++) begin
            check("t1_valid", out_valid, 1);
            check("t1_idx", out_idx, k);
            if (k == 0)  check("t1_data0", out_data, 32'h00000000);
            if (k == 5)  check("t1_data5", out_data, 32'h00050005);
            if (k == 15) check("t1_data15", out_data, 32'h000F000F);
            check("t1_last", out_last, (k == 15));
            tick();
        end
        check("t1_done_valid", out_valid, 0);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_drop_cnt", drop_cnt, 0);

        // Backpressure pattern 1,0,0,1
        do_reset();
        put_frame(1);
        hs = 0;
        for (int c = 0; c < 100; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            if (out_valid && out_ready) hs++;
            tick();
        end
        check("t2_handshakes", hs, 16);
        check("t2_frame_cnt", frame_cnt, 1);

        // Both banks full, new frame lands on the final handshake
        do_reset();
        out_ready = 1'b0;
        put_frame(2);
        put_frame(3);
        check("t4_busy", busy, 1);
        out_ready = 1'b1;
        wait_idx(4'd15, ok);
        check("t4_wait_idx15", ok, 1);
        put_frame(4);
        check("t4_drop_cnt", drop_cnt, 0);
        check("t4_overflow", overflow, 0);
        check("t4_next_data", out_data, pt(3, 0));
        wait_idle(ok);
        check("t4_wait_idle", ok, 1);
        check("t4_frame_cnt", frame_cnt, 3);

        // Three frames with sink stalled: third is dropped
        do_reset();
        out_ready = 1'b0;
        put_frame(10);
        put_frame(11);
        put_frame(12);
        check("t3_overflow", overflow, 1);
        check("t3_drop_cnt", drop_cnt, 1);
        check("t3_hold_data", out_data, pt(10, 0));
        out_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 32; c++) begin
            if (out_valid && out_ready) hs++;
            tick();
        end
        check("t3_handshakes", hs, 32);
        check("t3_frame_cnt", frame_cnt, 2);
        check("t3_idle", out_valid, 0);

        // Reset mid-frame with a second frame pending
        put_frame(20);
        put_frame(21);
        wait_idx(4'd7, ok);
        check("t5_wait_idx7", ok, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_frame_cnt", frame_cnt, 0);
        check("t5_overflow", overflow, 0);
        put_frame(22);
        tick();
        check("t5_restart_valid", out_valid, 1);
        check("t5_restart_idx", out_idx, 0);
        check("t5_restart_data", out_data, pt(22, 0));
        wait_idle(ok);
        check("t5_wait_idle", ok, 1);
        check("t5_frame_cnt_after", frame_cnt, 1);

        // Drop counter saturation
        do_reset();
        out_ready = 1'b0;
        put_frame(30);
        put_frame(31);
        for (int i = 0; i < 16; i++) din[i] = pt(32, i);
        fft_valid = 1'b1;
        repeat (300) tick();
        fft_valid = 1'b0;
        check("t6_drop_sat", drop_cnt, 255);
        check("t6_overflow", overflow, 1);

        // Frame counter wrap
        do_reset();
        out_ready = 1'b1;
        for (int f = 0; f < 257; f++) begin
            put_frame(100 + f);
            repeat (15) tick();
        end
        wait_idle(ok);
        check("t6_wait_idle", ok, 1);
        check("t6_frame_wrap", frame_cnt, 1);
        check("t6_no_drop", drop_cnt, 0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
